// File: rtl/input_sram_fetch_sequencer.sv
// rtl/input_sram_fetch_sequencer.sv - 2-D tile read sequencer with 2-entry output FIFO
module input_sram_fetch_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  row_len,
    input  logic [CNT_W-1:0]  row_count,
    input  logic [ADDR_W-1:0] row_stride,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              w_busy,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic              d_ready,
    input  logic [DATA_W-1:0] r_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    rows_q, rows_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic                coll_q, coll_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   fifo_data_q [2];
    logic [1:0]          fifo_last_q;
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          fifo_cnt_q;

    logic                push, pop, flush;
    logic                addr_ok, last_word;

    // Current element address; stays put while a read is outstanding.
    assign r_addr    = row_base_q + ADDR_W'(col_q);
    assign addr_ok   = (r_addr[ADDR_W-1:14] == '0) && (r_addr[13:11] <= 3'd5);
    assign last_word = (row_q == rows_q - CNT_W'(1)) && (col_q == len_q - CNT_W'(1));

    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = out_valid & fifo_last_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;

    // Sequencer state and descriptor registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            rows_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            coll_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rows_q     <= rows_d;
            row_q      <= row_d;
            col_q      <= col_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            coll_q     <= coll_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state, read issue and tile walk.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rows_d     = rows_q;
        row_d      = row_q;
        col_d      = col_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        coll_d     = coll_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        r_en       = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = row_len;
                    rows_d     = row_count;
                    stride_d   = row_stride;
                    row_base_d = base_addr;
                    row_d      = '0;
                    col_d      = '0;
                    coll_d     = 1'b0;
                    if (row_len == '0 || row_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!addr_ok) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (!w_busy && fifo_cnt_q <= 2'd1) begin
                    r_en    = 1'b1;
                    coll_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (d_ready) begin
                    state_d = S_ISSUE;
                    // A write during the wait may have corrupted the read: drop it and re-issue.
                    if (!coll_q) begin
                        push = 1'b1;
                        if (col_q == len_q - CNT_W'(1)) begin
                            col_d      = '0;
                            row_d      = row_q + CNT_W'(1);
                            row_base_d = row_base_q + stride_q;
                        end else begin
                            col_d = col_q + CNT_W'(1);
                        end
                        if (last_word) begin
                            state_d = S_DRAIN;
                        end
                    end
                end else if (w_busy) begin
                    coll_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry output FIFO; an aborted tile empties it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_cnt_q     <= '0;
        end else if (flush) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= r_d;
                fifo_last_q[wr_ptr_q] <= last_word;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_input_sram_fetch_sequencer.sv
// tb/tb_input_sram_fetch_sequencer.sv - self-checking bench for input_sram_fetch_sequencer
module tb_input_sram_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] row_len = '0;
    logic [15:0] row_count = '0;
    logic [31:0] row_stride = '0;
    logic        busy, done, err;
    logic        w_busy = 1'b0;
    logic        r_en;
    logic [31:0] r_addr;
    logic        d_ready = 1'b0;
    logic [63:0] r_d = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_last;

    input_sram_fetch_sequencer #(.ADDR_W(32), .DATA_W(64), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .row_len(row_len), .row_count(row_count), .row_stride(row_stride),
        .busy(busy), .done(done), .err(err), .w_busy(w_busy), .r_en(r_en),
        .r_addr(r_addr), .d_ready(d_ready), .r_d(r_d), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int total = 0;
    int bad   = 0;

    // Expected tile: addresses the sequencer must deliver, and whether it must abort.
    logic [31:0] exp_addr [64];
    int          exp_n = 0;
    bit          exp_err = 0;

    int issue_idx = 0, pop_idx = 0, n_ren = 0, n_done = 0, n_err = 0;
    int first_ren_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1, done_cyc = -1, start_cyc = 0;
    logic [31:0] first_addr = '0;
    logic [63:0] last_pop_data = '0;
    bit outst = 0, coll = 0;
    bit s_ren = 0;
    logic [31:0] s_addr = '0;
    bit pv = 0, pr = 0, plast = 0;
    logic [63:0] pdata = '0;

    function automatic logic [63:0] fdat(input logic [31:0] a);
        return {a ^ 32'h5A5A0000, ~a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Controller model: response two cycles after each accepted request.
    bit          rq_v = 0;
    logic [31:0] rq_a = '0;
    always @(posedge clock) begin
        #1;
        d_ready = rq_v;
        r_d     = rq_v ? fdat(rq_a) : 64'h0;
        rq_v    = s_ren;
        rq_a    = s_addr;
    end

    // Compare process: every cycle, check requests and FIFO hand-offs against the model.
    always @(negedge clock) begin
        s_ren  = r_en && reset;
        s_addr = r_addr;
        if (!reset) begin
            outst = 0;
            coll  = 0;
            pv    = 0;
        end else begin
            if (r_en) begin
                n_ren++;
                if (w_busy) chk("r_en_while_w_busy", 64'(r_en), 64'h0);
                chk("r_addr", {32'h0, r_addr}, (issue_idx < exp_n) ? {32'h0, exp_addr[issue_idx]} : 64'hBAD0BAD0);
                if (first_ren_cyc < 0) begin
                    first_ren_cyc = cyc;
                    first_addr    = r_addr;
                end
                outst = 1;
                coll  = 0;
            end else if (outst) begin
                if (d_ready) begin
                    outst = 0;
                    if (!coll) issue_idx++;
                end else if (w_busy) begin
                    coll = 1;
                end
            end
            if (pv && !pr) begin
                chk("hold_valid", 64'(out_valid), 64'h1);
                chk("hold_data", out_data, pdata);
                chk("hold_last", 64'(out_last), 64'(plast));
            end
            if (out_valid && out_ready) begin
                if (pop_idx < exp_n) begin
                    chk("out_data", out_data, fdat(exp_addr[pop_idx]));
                    chk("out_last", 64'(out_last), 64'(!exp_err && pop_idx == exp_n - 1));
                end else begin
                    chk("extra_word", 64'(pop_idx), 64'(exp_n - 1));
                end
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc  = cyc;
                last_pop_data = out_data;
                pop_idx++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (err) n_err++;
            pv    = out_valid;
            pr    = out_ready;
            pdata = out_data;
            plast = out_last;
        end
    end

    task automatic setup(input logic [31:0] base, input logic [15:0] len,
                         input logic [15:0] cnt, input logic [31:0] stride);
        logic [31:0] a;
        exp_n   = 0;
        exp_err = 0;
        for (int r = 0; r < int'(cnt); r++) begin
            for (int c = 0; c < int'(len); c++) begin
                if (!exp_err) begin
                    a = base + 32'(r) * stride + 32'(c);
                    if (a >= 32'd12288) exp_err = 1;
                    else if (exp_n < 64) begin
                        exp_addr[exp_n] = a;
                        exp_n++;
                    end
                end
            end
        end
        issue_idx = 0; pop_idx = 0; n_ren = 0; n_done = 0; n_err = 0;
        first_ren_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
        outst = 0; coll = 0;
        base_addr = base; row_len = len; row_count = cnt; row_stride = stride;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int k;
        k = 0;
        while (n_done + n_err == 0 && k < 400) begin
            tick();
            k++;
        end
        if (n_done + n_err == 0) chk({nm, "_timeout"}, 64'(k), 64'h0);
        tick();
        tick();
    endtask

    task automatic wait_ren(input string nm);
        int k;
        k = 0;
        while (!r_en && k < 50) begin
            tick();
            k++;
        end
        if (!r_en) chk({nm, "_ren_timeout"}, 64'(k), 64'h0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_r_en", 64'(r_en), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_last", 64'(out_last), 64'h0);
        chk("rst_r_addr", {32'h0, r_addr}, 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        reset = 1'b1;
        tick(); tick();

        // Two-row tile, no backpressure
        setup(32'h10, 16'd4, 16'd2, 32'h100);
        chk("t1_busy_t1", 64'(busy), 64'h1);
        chk("t1_ren_t1", 64'(r_en), 64'h1);
        wait_end("t1");
        chk("t1_first_addr", {32'h0, first_addr}, 64'h10);
        chk("t1_last_data", last_pop_data, 64'h5A5A0113_FFFFFEEC);
        chk("t1_nren", 64'(n_ren), 64'd8);
        chk("t1_npop", 64'(pop_idx), 64'd8);
        chk("t1_ndone", 64'(n_done), 64'd1);
        chk("t1_nerr", 64'(n_err), 64'd0);
        chk("t1_busy_after", 64'(busy), 64'h0);
        chk("t1_out_latency", 64'(first_pop_cyc - first_ren_cyc), 64'd3);
        chk("t1_ren_latency", 64'(first_ren_cyc - start_cyc), 64'd1);
        chk("t1_done_latency", 64'(done_cyc - last_pop_cyc), 64'd1);

        // Empty tile
        setup(32'h20, 16'd0, 16'd3, 32'h10);
        chk("t2_done", 64'(done), 64'h1);
        chk("t2_busy", 64'(busy), 64'h0);
        chk("t2_ren", 64'(r_en), 64'h0);
        tick(); tick(); tick();
        chk("t2_done_pulse", 64'(done), 64'h0);
        chk("t2_nren", 64'(n_ren), 64'd0);
        chk("t2_ndone", 64'(n_done), 64'd1);

        // Range abort at 0x3000
        setup(32'h2FFE, 16'd4, 16'd1, 32'h0);
        wait_end("t3");
        repeat (5) tick();
        chk("t3_nren", 64'(n_ren), 64'd2);
        chk("t3_npop", 64'(pop_idx), 64'd2);
        chk("t3_nerr", 64'(n_err), 64'd1);
        chk("t3_ndone", 64'(n_done), 64'd0);
        chk("t3_busy", 64'(busy), 64'h0);

        // Writer stalls the issue, then collides with a read in flight
        w_busy = 1'b1;
        setup(32'h40, 16'd3, 16'd1, 32'h0);
        repeat (4) tick();
        chk("t4_ren_during_wbusy", 64'(n_ren), 64'd0);
        tick();
        w_busy = 1'b0;
        #1;
        wait_ren("t4");
        tick();
        w_busy = 1'b1;
        tick();
        w_busy = 1'b0;
        wait_end("t4");
        chk("t4_nren", 64'(n_ren), 64'd4);
        chk("t4_npop", 64'(pop_idx), 64'd3);
        chk("t4_ndone", 64'(n_done), 64'd1);

        // Consumer backpressure
        out_ready = 1'b0;
        setup(32'h0, 16'd6, 16'd1, 32'h0);
        repeat (20) tick();
        chk("t5_nren_stalled", 64'(n_ren), 64'd2);
        chk("t5_valid_stalled", 64'(out_valid), 64'h1);
        out_ready = 1'b1;
        wait_end("t5");
        chk("t5_nren", 64'(n_ren), 64'd6);
        chk("t5_npop", 64'(pop_idx), 64'd6);
        chk("t5_ndone", 64'(n_done), 64'd1);

        // Reset while a read is outstanding, then a clean tile
        setup(32'h200, 16'd4, 16'd1, 32'h0);
        wait_ren("t6");
        tick();
        reset = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'h0);
        chk("t6_r_en", 64'(r_en), 64'h0);
        chk("t6_out_valid", 64'(out_valid), 64'h0);
        chk("t6_r_addr", {32'h0, r_addr}, 64'h0);
        chk("t6_out_data", out_data, 64'h0);
        chk("t6_done_err", 64'({done, err, out_last}), 64'h0);
        #1;
        reset = 1'b1;
        outst = 0;
        exp_n = 0;
        pop_idx = 0;
        repeat (6) tick();
        chk("t6_stray_valid", 64'(out_valid), 64'h0);
        chk("t6_stray_pop", 64'(pop_idx), 64'd0);
        chk("t6_stray_busy", 64'(busy), 64'h0);
        setup(32'h300, 16'd2, 16'd1, 32'h0);
        wait_end("t6b");
        chk("t6b_npop", 64'(pop_idx), 64'd2);
        chk("t6b_ndone", 64'(n_done), 64'd1);
        chk("t6b_nren", 64'(n_ren), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal;
    end

endmodule

// File: doc/input_sram_fetch_sequencer.md
# input_sram_fetch_sequencer

Read-side initiator for the input-activation SRAM controller. Given a 2-D tile descriptor (base, row length, row count, row stride), it issues single-word reads over the controller's `r_en`/`r_addr`/`d_ready`/`r_d` handshake. It buffers the returned 64-bit words in a 2-entry output FIFO and streams them to the PE-array feeder over valid/ready with a last-word flag. It defers to the write path: it never issues a read while the loader is writing.

## Interface
- `ADDR_W`, 32: SRAM word-address width (matches controller `r_addr`).
- `DATA_W`, 64: SRAM word width (matches controller `r_d`).
- `CNT_W`, 16: width of row length / row count fields.
- `clock`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches descriptor when idle.
- `base_addr`  in  ADDR_W  word address of tile element (0,0).
- `row_len`  in  CNT_W  words per row.
- `row_count`  in  CNT_W  number of rows.
- `row_stride`  in  ADDR_W  word distance between row starts.
- `busy`  out  1  high from accepted start until done/err pulse.
- `done`  out  1  one-cycle pulse: last word handed off, or empty tile.
- `err`  out  1  one-cycle pulse: out-of-range address, tile aborted.
- `w_busy`  in  1  writer is driving `w_en` to the controller this cycle.
- `r_en`  out  1  read request to controller.
- `r_addr`  out  ADDR_W  read address; held stable from issue until `d_ready`.
- `d_ready`  in  1  controller response strobe; `r_d` valid this cycle.
- `r_d`  in  DATA_W  read data.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head when both high.
- `out_data`  out  DATA_W  FIFO head word.
- `out_last`  out  1  head is final word of tile.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - `start` latches the descriptor and clears `row` and `col`.
  - If `row_len==0` or `row_count==0`, pulse `done` next cycle and stay IDLE.
  - Otherwise go to ISSUE.
  - `start` in any other state is ignored.
- Address computation: `addr = row_base + col`, with `row_base` accumulated by `+row_stride` per row. Arithmetic is modulo 2^ADDR_W.
- Range check, applied before issue: an address is legal iff bits [ADDR_W-1:14] are zero and bits [13:11] ≤ 5, i.e. 0..12287. An illegal address produces an `err` pulse, flushes the FIFO, and returns to IDLE with no `r_en`.
- ISSUE:
  - Assert `r_en` for exactly one cycle when `w_busy==0` and (FIFO occupancy + 1) ≤ 2.
  - Otherwise stall with `r_en` low and `r_addr` held. Then go to WAIT.
- WAIT:
  - `r_en` low; wait for `d_ready`. No latency is assumed.
  - On `d_ready`, push `r_d` and tag `last` if `row==row_count-1` and `col==row_len-1`.
  - Advance `col`; at `row_len` wrap `col` to 0 and advance the row. Go to ISSUE, or to DRAIN after the last word.
- Write collision: if `w_busy` is high in any WAIT cycle before `d_ready`, that response is discarded. The same address is then re-issued via ISSUE.
- DRAIN: when the `last`-tagged word is popped, pulse `done`, drop `busy`, go to IDLE.
- FIFO: 2 entries. Push and pop in the same cycle are allowed. FIFO is never full at push, guaranteed by the issue rule.

## Timing
- Reset values: `busy`, `done`, `err`, `r_en`, `out_valid`, `out_last` = 0; `r_addr`, `out_data` = 0; state IDLE; FIFO empty.
- Reset mid-tile abandons everything immediately. An outstanding controller response after reset release is ignored (state IDLE).
- `start` in cycle t: `busy` high in t+1, first `r_en` in t+1 (if `w_busy` low).
- With the controller's 2-cycle response (`r_en` in cycle k, `d_ready` in k+2), `out_valid` rises in k+3. Throughput is 1 word per 3 cycles with no backpressure.
- `done` occurs in the cycle after the last-word pop. `busy` falls in the same cycle as `done`/`err`.
- `out_data`/`out_last` are stable while `out_valid && !out_ready`.

## Test plan
- base=0x10, row_len=4, row_count=2, stride=0x100, `out_ready`=1 → reads at 0x10–0x13 and 0x110–0x113 in order; `out_last` only on the 0x113 word; one `done`; `busy` low afterwards.
- row_len=0, `start` → `done` pulse in t+1, no `r_en`, `busy` stays 0.
- base=0x2FFE, row_len=4, row_count=1 → reads 0x2FFE and 0x2FFF delivered; 0x3000 fails the range check, giving `err` with no third `r_en` and `done` never pulsed.
- `w_busy` held high 5 cycles during ISSUE, then pulsed during WAIT → no `r_en` while `w_busy`; the collided address is re-read once; the output sequence has no duplicates or gaps.
- `out_ready`=0 for 20 cycles, base=0, row_len=6, row_count=1 → at most 2 reads complete and then `r_en` stalls; after `out_ready`=1 all 6 words arrive in order.
- `reset` asserted while in WAIT → all outputs 0 immediately; a stray `d_ready` after release pushes nothing; a new `start` works normally.
